hdc_encoder_stream: RTL and testbench
=====================================

Name: hdc_encoder_stream

Overview:
- Parametrised successor of the sparse HDC encoding top. Binds FEATURE_COUNT level hypervectors by per-feature circular rotation, then bundles them by popcount thresholding, DIMS_PER_CC dimensions per cycle.
- Adds a valid/ready handshake on both sides, a runtime threshold, and support for HV_DIM not divisible by DIMS_PER_CC.
- Sits between the level-HV lookup stage and the associative-memory/classifier stage.

Parameters:
- HV_DIM, 80: hypervector width in bits.
- FEATURE_COUNT, 40: number of level HVs bundled per sample; must be ≤ hdc_enc_pkg::MAX_FEATURES.
- DIMS_PER_CC, 8: dimensions thresholded per clock; must be ≥ 1.
- CNT_W, $clog2(FEATURE_COUNT+1): popcount/threshold width (derived).
- NUM_CHUNKS, ceil(HV_DIM/DIMS_PER_CC): bundle cycles per sample (derived).

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, all state freezes.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept; equals (state==IDLE) && en.
- level_hvs  in  HV_DIM x [0:FEATURE_COUNT-1]  unpacked array of level HVs.
- threshold  in  CNT_W  bundle threshold; sampled on accept.
- out_valid  out  1  encoded_hv valid.
- out_ready  in  1  consumer accepts.
- encoded_hv  out  HV_DIM  bundled result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, nrst=0): state=IDLE, chunk counter=0, bound regs=0, threshold reg=0, encoded_hv=0, out_valid=0, busy=0. Reset mid-operation discards the sample and the partial result.
- Binding: bound[i][(j+S_i) mod HV_DIM] = level_hvs[i][j], i.e. rotate left by S_i. S_i = hdc_enc_pkg::SHIFTS[i] mod HV_DIM, computed at elaboration, no runtime logic.
- States:
  - IDLE: on en && in_valid && in_ready, the edge registers all bound HVs and the threshold, clears the chunk counter, and goes to BUNDLE. encoded_hv keeps its old value.
  - BUNDLE: each en cycle handles chunk c = counter.
    - For d in 0..DIMS_PER_CC-1, dim j = c*DIMS_PER_CC+d.
    - encoded_hv[j] <= (popcount_i bound[i][j] >= threshold_reg).
    - Dims with j ≥ HV_DIM (last partial chunk) are ignored; no write out of range.
    - Counter increments each cycle. On c == NUM_CHUNKS-1 go to OUT and set out_valid=1.
  - OUT: out_valid=1 and encoded_hv held stable. On en && out_ready: out_valid<=0, go to IDLE.
- Latency: accept at edge k gives out_valid=1 after edge k+NUM_CHUNKS (defaults: 10 cycles) when en stays high. Each en=0 cycle adds one cycle.
- No input accept is possible in OUT or BUNDLE; in_ready=0. Back-to-back throughput is one sample per NUM_CHUNKS+2 cycles.
- threshold=0 gives all ones. threshold > FEATURE_COUNT gives all zeros. Popcount is CNT_W bits wide and does not saturate.
- en=0 freezes state, counter, and all registers; the handshake outputs hold, except in_ready=0.
- Simultaneous in_valid with out_ready in OUT: the output transfer completes and the input waits one cycle for IDLE.
- Bit order: bit j of result = dimension j; feature ordering does not affect the result.

Decomposition:
- Package hdc_enc_pkg holds:
  - MAX_FEATURES
  - the SHIFTS table (int array [0:MAX_FEATURES-1])
  - the state enum enc_state_e {IDLE, BUNDLE, OUT}
  - helper function ceil_div
- Sub-module hdc_bundle_slice (param FEATURE_COUNT, CNT_W) takes a FEATURE_COUNT-bit vector and a threshold, and gives a 1-bit result: combinational popcount plus compare. It is instantiated DIMS_PER_CC times.
- A per-dimension transposition mux selects the chunk by counter, using a generate loop, not a case list.

Test Plan:
- Reset: assert nrst=0 mid-BUNDLE → same cycle: out_valid=0, busy=0, encoded_hv=0; after release in_ready=1 with en=1.
- All level_hvs=all-ones, threshold=1, defaults → out_valid rises exactly 10 cycles after accept edge; encoded_hv=all-ones. Repeat with threshold=41 → all-zeros.
- Only feature 0 bit 3 set and feature 1 bit 0 set (SHIFTS[1]=s), threshold=1 → encoded_hv has exactly bits 3 and s set (s≠3). With threshold=2 → all zeros unless s==3.
- HV_DIM=20, DIMS_PER_CC=8 config, all-ones input, threshold=0 → NUM_CHUNKS=3, out_valid after 3 cycles, encoded_hv=20'hFFFFF, no X/out-of-range writes.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, encoded_hv stable. Then out_ready=1 → next sample accepted one cycle after the transfer.
- en low 3 cycles mid-BUNDLE → out_valid delayed exactly 3 cycles; result bit-identical to the uninterrupted run.

Source files
------------

// File: rtl/hdc_enc_pkg.sv
// Shared definitions for the streaming HDC encoder: feature limits, the
// per-feature rotation table, the controller state type and a sizing helper.
package hdc_enc_pkg;

  localparam int MAX_FEATURES = 64;

  // Rotation applied to feature i before bundling. Each entry is reduced
  // modulo HV_DIM inside the encoder, so entries may exceed the HV width.
  localparam int SHIFTS [0:MAX_FEATURES-1] = '{
      0,   7,  14,  21,  28,  35,  42,  49,
     56,  63,  70,  77,  84,  91,  98, 105,
    112, 119, 126, 133, 140, 147, 154, 161,
    168, 175, 182, 189, 196, 203, 210, 217,
    224, 231, 238, 245, 252, 259, 266, 273,
    280, 287, 294, 301, 308, 315, 322, 329,
    336, 343, 350, 357, 364, 371, 378, 385,
    392, 399, 406, 413, 420, 427, 434, 441
  };

  typedef enum logic [1:0] {
    IDLE,
    BUNDLE,
    OUT
  } enc_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/hdc_bundle_slice.sv
// One bundling lane: counts the set bits of one dimension across all
// features and reports whether the count reaches the threshold.
module hdc_bundle_slice
  import hdc_enc_pkg::*;
#(
  parameter int FEATURE_COUNT = 40,
  parameter int CNT_W         = $clog2(FEATURE_COUNT + 1)
) (
  input  logic [FEATURE_COUNT-1:0] bits,
  input  logic [CNT_W-1:0]         threshold,
  output logic                     hit
);

  logic [CNT_W-1:0] count;

  // Popcount of the feature column for this dimension.
  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely
    // combinational (no latch), and blocking '=' is what lets the running
    // sum carry from one iteration to the next.
    count = '0;
    for (int i = 0; i < FEATURE_COUNT; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

  assign hit = (count >= threshold);

endmodule

// File: rtl/hdc_encoder_stream.sv
// Streaming HDC encoder: binds FEATURE_COUNT level hypervectors by fixed
// per-feature rotation, then bundles them by popcount thresholding,
// DIMS_PER_CC dimensions per clock, with valid/ready on both sides.
module hdc_encoder_stream
  import hdc_enc_pkg::*;
#(
  parameter int HV_DIM        = 80,
  parameter int FEATURE_COUNT = 40,
  parameter int DIMS_PER_CC   = 8,
  parameter int CNT_W         = $clog2(FEATURE_COUNT + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] level_hvs [0:FEATURE_COUNT-1],
  input  logic [CNT_W-1:0]  threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] encoded_hv,
  output logic              busy
);

  localparam int NUM_CHUNKS = ceil_div(HV_DIM, DIMS_PER_CC);
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  if (FEATURE_COUNT > MAX_FEATURES || FEATURE_COUNT < 1 || DIMS_PER_CC < 1)
  begin : g_bad_cfg
    $error("hdc_encoder_stream: unsupported FEATURE_COUNT/DIMS_PER_CC");
  end

  enc_state_e              state;
  logic [CHUNK_W-1:0]      chunk;
  logic [CNT_W-1:0]        thr_q;
  logic [HV_DIM-1:0]       enc_q;
  logic [HV_DIM-1:0]       enc_next;
  logic [HV_DIM-1:0]       bound_d [0:FEATURE_COUNT-1];
  logic [HV_DIM-1:0]       bound_q [0:FEATURE_COUNT-1];
  logic [FEATURE_COUNT-1:0] column  [0:NUM_CHUNKS-1][0:DIMS_PER_CC-1];
  logic [FEATURE_COUNT-1:0] slice_in [0:DIMS_PER_CC-1];
  logic [DIMS_PER_CC-1:0]   slice_hit;

  // Binding: fixed rotate-left per feature, pure wiring. For a shift of 0 the
  // right shift by HV_DIM yields zero and the result is the input unchanged.
  for (genvar i = 0; i < FEATURE_COUNT; i++) begin : g_bind
    localparam int S = SHIFTS[i] % HV_DIM;
    assign bound_d[i] = (level_hvs[i] << S) | (level_hvs[i] >> (HV_DIM - S));
  end

  // Transposition: column[c][d] holds dimension c*DIMS_PER_CC+d across all
  // features; dimensions past HV_DIM in the last chunk read as zero.
  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
    for (genvar d = 0; d < DIMS_PER_CC; d++) begin : g_lane
      localparam int DIM = c * DIMS_PER_CC + d;
      for (genvar i = 0; i < FEATURE_COUNT; i++) begin : g_feat
        if (DIM < HV_DIM) begin : g_real
          assign column[c][d][i] = bound_q[i][DIM];
        end else begin : g_pad
          assign column[c][d][i] = 1'b0;
        end
      end
    end
  end

  // Chunk mux and bundling lanes.
  for (genvar d = 0; d < DIMS_PER_CC; d++) begin : g_slice
    assign slice_in[d] = column[chunk][d];

    hdc_bundle_slice #(
      .FEATURE_COUNT (FEATURE_COUNT),
      .CNT_W         (CNT_W)
    ) u_slice (
      .bits      (slice_in[d]),
      .threshold (thr_q),
      .hit       (slice_hit[d])
    );
  end

  // Result update: each real dimension belongs to exactly one chunk, so only
  // the current chunk's bits take the lane results; padding lanes go nowhere.
  for (genvar j = 0; j < HV_DIM; j++) begin : g_write
    localparam int C = j / DIMS_PER_CC;
    localparam int D = j % DIMS_PER_CC;
    assign enc_next[j] = (chunk == CHUNK_W'(C)) ? slice_hit[D] : enc_q[j];
  end

  // Controller: accept, bundle chunk by chunk, then hold the result until taken.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      chunk     <= '0;
      thr_q     <= '0;
      enc_q     <= '0;
      out_valid <= 1'b0;
      // NOTE: the bound array is state that must read as zero after reset,
      // so it is cleared here like any other register.
      for (int i = 0; i < FEATURE_COUNT; i++) begin
        bound_q[i] <= '0;
      end
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < FEATURE_COUNT; i++) begin
              bound_q[i] <= bound_d[i];
            end
            thr_q <= threshold;
            chunk <= '0;
            state <= BUNDLE;
          end
        end
        BUNDLE: begin
          enc_q <= enc_next;
          if (chunk == LAST_CHUNK) begin
            chunk     <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE) && en;
  assign busy       = (state != IDLE);
  assign encoded_hv = enc_q;

endmodule

// File: tb/tb_hdc_encoder_stream.sv
// Directed bench for hdc_encoder_stream: default 80-bit instance plus a
// 20-bit instance whose last chunk is partial.
module tb_hdc_encoder_stream;

  localparam int HV  = 80;
  localparam int HVS = 20;
  localparam int FC  = 40;
  localparam logic [HV-1:0] ONES = {HV{1'b1}};

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [HV-1:0] lvl [0:FC-1];
  logic [5:0]    thr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [HV-1:0] enc;
  logic          busy;

  logic           in_valid_s = 1'b0;
  logic           in_ready_s;
  logic [HVS-1:0] lvl_s [0:FC-1];
  logic [5:0]     thr_s = '0;
  logic           out_valid_s;
  logic           out_ready_s = 1'b0;
  logic [HVS-1:0] enc_s;
  logic           busy_s;

  int total = 0;
  int bad   = 0;

  hdc_encoder_stream dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .level_hvs  (lvl),
    .threshold  (thr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .encoded_hv (enc),
    .busy       (busy)
  );

  hdc_encoder_stream #(.HV_DIM(HVS), .FEATURE_COUNT(FC), .DIMS_PER_CC(8)) dut_s (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .in_valid   (in_valid_s),
    .in_ready   (in_ready_s),
    .level_hvs  (lvl_s),
    .threshold  (thr_s),
    .out_valid  (out_valid_s),
    .out_ready  (out_ready_s),
    .encoded_hv (enc_s),
    .busy       (busy_s)
  );

  task automatic check(input string tag, input logic [HV-1:0] got, input logic [HV-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic bit_val);
    for (int i = 0; i < FC; i++) lvl[i] = {HV{bit_val}};
  endtask

  // Accept one sample on the big instance, wait for out_valid (optionally with
  // a 3-cycle en gap starting gap_start cycles after accept), check latency
  // and result, and optionally drain it.
  task automatic run(input string tag, input logic [5:0] t, input int exp_lat,
                     input logic [HV-1:0] exp_hv, input int gap_start, input bit consume);
    int lat;
    thr = t;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, HV'(in_ready), HV'(1));
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, HV'(busy), HV'(1));
    lat = 0;
    while (!out_valid && lat < 60) begin
      en = !(gap_start >= 0 && lat >= gap_start && lat < gap_start + 3);
      step();
      lat++;
    end
    en = 1'b1;
    check({tag, "_latency"}, HV'(lat), HV'(exp_lat));
    check({tag, "_hv"}, enc, exp_hv);
    if (consume) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_drained"}, HV'(out_valid), HV'(0));
    end
  endtask

  // Same flow for the 20-bit instance, always drained.
  task automatic run_s(input string tag, input logic [5:0] t, input logic [HVS-1:0] exp_hv);
    int lat;
    thr_s = t;
    in_valid_s = 1'b1;
    check({tag, "_in_ready"}, HV'(in_ready_s), HV'(1));
    step();
    in_valid_s = 1'b0;
    lat = 0;
    while (!out_valid_s && lat < 60) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, HV'(lat), HV'(3));
    check({tag, "_hv"}, HV'(enc_s), HV'(exp_hv));
    out_ready_s = 1'b1;
    step();
    out_ready_s = 1'b0;
    check({tag, "_drained"}, HV'(out_valid_s), HV'(0));
  endtask

  initial begin
    fill(1'b0);
    for (int i = 0; i < FC; i++) lvl_s[i] = '1;
    en = 1'b1;

    // Reset state.
    #22;
    check("rst_out_valid", HV'(out_valid), HV'(0));
    check("rst_busy", HV'(busy), HV'(0));
    check("rst_hv", enc, '0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    check("idle_in_ready", HV'(in_ready), HV'(1));
    en = 1'b0;
    #1;
    check("idle_en0_in_ready", HV'(in_ready), HV'(0));
    en = 1'b1;
    step();

    // All ones: threshold 1 gives all ones, threshold 41 gives all zeros.
    fill(1'b1);
    run("ones_t1", 6'd1, 10, ONES, -1, 1'b1);
    run("ones_t41", 6'd41, 10, '0, -1, 1'b1);

    // Two isolated bits: feature0 bit3 stays at 3, feature1 bit0 rotates to 7.
    fill(1'b0);
    lvl[0][3] = 1'b1;
    lvl[1][0] = 1'b1;
    run("pair_t1", 6'd1, 10, 80'h88, -1, 1'b1);
    run("pair_t2", 6'd2, 10, '0, -1, 1'b1);

    // All-zero input with threshold 0 still gives all ones.
    fill(1'b0);
    run("zero_t0", 6'd0, 10, ONES, -1, 1'b1);

    // Wrap-around: feature2 bit66 (+14) and feature3 bit59 (+21) both land on
    // dim 0; feature0 bit10 stays at 10; feature39 bit0 (+273 mod 80 = 33) at 33.
    lvl[0][10] = 1'b1;
    lvl[2][66] = 1'b1;
    lvl[3][59] = 1'b1;
    lvl[39][0] = 1'b1;
    run("wrap_t2", 6'd2, 10, 80'h1, -1, 1'b1);
    run("wrap_t1", 6'd1, 10, 80'h2_0000_0401, -1, 1'b0);

    // Backpressure: result held, no accept while the consumer stalls.
    fill(1'b0);
    lvl[0][3] = 1'b1;
    lvl[1][0] = 1'b1;
    thr = 6'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_in_ready", HV'(in_ready), HV'(0));
      check("bp_out_valid", HV'(out_valid), HV'(1));
      check("bp_hv_stable", enc, 80'h2_0000_0401);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_transfer_out_valid", HV'(out_valid), HV'(0));
    check("bp_transfer_busy", HV'(busy), HV'(0));
    run("bp_next", 6'd1, 10, 80'h88, -1, 1'b1);

    // en low for 3 cycles mid-bundle: 3 cycles later, identical result.
    fill(1'b0);
    lvl[0][10] = 1'b1;
    lvl[2][66] = 1'b1;
    lvl[3][59] = 1'b1;
    lvl[39][0] = 1'b1;
    run("gap_t1", 6'd1, 13, 80'h2_0000_0401, 4, 1'b1);

    // Reset mid-bundle clears everything at once.
    fill(1'b1);
    thr = 6'd41;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_busy_before_rst", HV'(busy), HV'(1));
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_out_valid", HV'(out_valid), HV'(0));
    check("mid_rst_busy", HV'(busy), HV'(0));
    check("mid_rst_hv", enc, '0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    check("post_rst_in_ready", HV'(in_ready), HV'(1));

    // Partial last chunk: 20 dims in 3 chunks of 8.
    run_s("small_t0", 6'd0, 20'hFFFFF);
    run_s("small_t40", 6'd40, 20'hFFFFF);
    run_s("small_t41", 6'd41, 20'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
